// File: rtl/pc_pkg.sv
// Shared opcode encoding and defaults for the program counter with return stack.
// Latency: none (types and constants only).
// Backpressure: none.
package pc_pkg;

   // Default geometry of the PC and of the return-address stack
   localparam int DEF_SIZE  = 12;
   localparam int DEF_DEPTH = 8;

   // One operation per edge; enum order mirrors decode priority after OP_NONE
   typedef enum logic [2:0] {
      OP_NONE = 3'd0,
      OP_CLR  = 3'd1,
      OP_LD   = 3'd2,
      OP_CALL = 3'd3,
      OP_RET  = 3'd4,
      OP_BR   = 3'd5,
      OP_INC  = 3'd6
   } op_e;

   // Fixed-priority decode: CLR > LD > CALL > RET > BR > INC > hold
   function automatic op_e op_decode(
      input logic clr,
      input logic ld,
      input logic call,
      input logic ret,
      input logic br,
      input logic inc
   );
      op_e op;
      if (clr)       op = OP_CLR;
      else if (ld)   op = OP_LD;
      else if (call) op = OP_CALL;
      else if (ret)  op = OP_RET;
      else if (br)   op = OP_BR;
      else if (inc)  op = OP_INC;
      else           op = OP_NONE;
      return op;
   endfunction

endpackage

// File: rtl/ret_stack.sv
// DEPTH x SIZE LIFO holding subroutine return addresses, updated on the falling clock edge.
// Latency: push/pop visible on sp/top/full/empty right after the acting edge; outputs derive from registers only.
// Backpressure: push while full and pop while empty are dropped; the caller raises the error flags.
module ret_stack
   import pc_pkg::*;
#(
   parameter int SIZE  = DEF_SIZE,
   parameter int DEPTH = DEF_DEPTH,
   localparam int SPW  = $clog2(DEPTH + 1),
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [SIZE-1:0] push_data,
   output logic [SPW-1:0]  sp,
   output logic [SIZE-1:0] top,
   output logic            full,
   output logic            empty
);

   logic [SIZE-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_idx;
   logic [AW-1:0]   top_idx;
   logic            do_push;
   logic            do_pop;

   // sp < DEPTH whenever a push is accepted, so the low bits address the free slot directly
   assign wr_idx  = sp[AW-1:0];
   // sp - 1 is in 0..DEPTH-1 whenever sp > 0, so modular subtraction on the low bits is exact
   assign top_idx = sp[AW-1:0] - AW'(1);

   assign full    = (sp == SPW'(DEPTH));
   assign empty   = (sp == '0);
   assign do_push = rst_n && push && !full;
   assign do_pop  = rst_n && pop && !push && !empty;

   // Top-of-stack read; forced to zero so stale RAM never leaks out when empty
   always_comb begin
      top = '0;
      if (!empty) top = mem[top_idx];
   end

   // Entry storage; not reset, only occupancy is cleared by reset
   always_ff @(negedge clk) begin
      if (do_push) mem[wr_idx] <= push_data;
   end

   // Occupancy counter with synchronous active-low reset
   always_ff @(negedge clk) begin
      if (!rst_n)       sp <= '0;
      else if (do_push) sp <= sp + SPW'(1);
      else if (do_pop)  sp <= sp - SPW'(1);
   end

   // Occupancy can never exceed the number of physical entries
   always_ff @(negedge clk) begin
      if (rst_n) assert (sp <= SPW'(DEPTH)) else $error("ret_stack occupancy out of range");
   end

endmodule

// File: rtl/pc_stack.sv
// Program counter with relative branch, CALL/RET return-address stack and sticky error flags.
// Latency: every operation is visible on outputs right after the acting falling edge; no input-to-output combinational path.
// Backpressure: none; CALL while full and RET while empty are dropped and latch OVF/UNF.
module pc_stack
   import pc_pkg::*;
#(
   parameter int SIZE    = DEF_SIZE,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int RST_VEC = 1,
   localparam int SPW    = $clog2(DEPTH + 1)
) (
   input  logic            CLK,
   input  logic            reset,
   input  logic            CLR,
   input  logic            LD,
   input  logic            CALL,
   input  logic            RET,
   input  logic            BR,
   input  logic            INC,
   input  logic            ERR_CLR,
   input  logic [SIZE-1:0] PC_INP,
   input  logic [SIZE-1:0] OFFSET,
   output logic [SIZE-1:0] PC_OUT,
   output logic [SIZE-1:0] TOP,
   output logic [SPW-1:0]  SP,
   output logic            FULL,
   output logic            EMPTY,
   output logic            OVF,
   output logic            UNF
);

   localparam logic [SIZE-1:0] RST_PC = SIZE'(RST_VEC);

   op_e             op;
   logic [SIZE-1:0] pc;
   logic [SIZE-1:0] pc_nxt;
   logic [SIZE-1:0] pc_inc;
   logic            push;
   logic            pop;
   logic            ovf;
   logic            unf;
   logic            ovf_set;
   logic            unf_set;

   assign op      = op_decode(CLR, LD, CALL, RET, BR, INC);
   assign pc_inc  = pc + SIZE'(1);

   // Stack side effects only when the guarded operation actually executes
   assign push    = (op == OP_CALL) && !FULL;
   assign pop     = (op == OP_RET) && !EMPTY;
   assign ovf_set = (op == OP_CALL) && FULL;
   assign unf_set = (op == OP_RET) && EMPTY;

   ret_stack #(
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
   ) u_ret_stack (
      .clk       (CLK),
      .rst_n     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (pc_inc),
      .sp        (SP),
      .top       (TOP),
      .full      (FULL),
      .empty     (EMPTY)
   );

   // Next PC selection; dropped CALL/RET hold the current value
   always_comb begin
      pc_nxt = pc;
      case (op)
         OP_CLR:  pc_nxt = '0;
         OP_LD:   pc_nxt = PC_INP;
         OP_CALL: if (!FULL)  pc_nxt = PC_INP;
         OP_RET:  if (!EMPTY) pc_nxt = TOP;
         OP_BR:   pc_nxt = pc + OFFSET;
         OP_INC:  pc_nxt = pc_inc;
         default: pc_nxt = pc;
      endcase
   end

   // PC register with synchronous active-low reset to the reset vector
   always_ff @(negedge CLK) begin
      if (!reset) pc <= RST_PC;
      else        pc <= pc_nxt;
   end

   // Sticky error flags; a new error in the same cycle as ERR_CLR keeps the flag set
   always_ff @(negedge CLK) begin
      if (!reset) begin
         ovf <= 1'b0;
         unf <= 1'b0;
      end else begin
         ovf <= ovf_set | (ovf & ~ERR_CLR);
         unf <= unf_set | (unf & ~ERR_CLR);
      end
   end

   assign PC_OUT = pc;
   assign OVF    = ovf;
   assign UNF    = unf;

endmodule
